// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, immediate and control
// generation, load-use hazard detection, and the ID/EX pipeline register feeding EX.
module decode_stage #(
    parameter bit          CLEAR_RF  = 1'b1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic        StallD,
    output logic        ValidE,
    output logic [10:0] CtrlE,
    output logic [2:0]  Funct3E,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [31:0] InstrE,
    output logic        IllegalE
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // funct7[5] selects SUB only for register-register ops, but SRA for both shift forms
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt,
                                           input logic allow_sub);
        case (funct3)
            3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0] regs [32];
    logic        rf_we;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rf_rs1, rf_rs2;

    logic        reg_write, mem_write, alu_src, branch, jump;
    logic [1:0]  result_src;
    alu_op_t     alu_ctrl;
    logic        rs1_used, rs2_used, illegal, is_auipc;
    logic [31:0] imm_d, rd1_d, rd2_d;
    logic        hazard;

    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];
    assign funct3 = InstrD[14:12];
    assign alt    = InstrD[30];

    assign imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_u = {InstrD[31:12], 12'b0};
    assign imm_j = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // Bypass lets ID/EX capture a value written back on the very same edge
    assign rf_we  = RegWriteW && (RdW != 5'd0);
    assign rf_rs1 = (rs1 == 5'd0) ? 32'd0 : (rf_we && RdW == rs1) ? ResultW : regs[rs1];
    assign rf_rs2 = (rs2 == 5'd0) ? 32'd0 : (rf_we && RdW == rs2) ? ResultW : regs[rs2];

    generate
        if (CLEAR_RF) begin : gen_rf_clear
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < 32; i++) regs[i] <= '0;
                end else if (rf_we) begin
                    regs[RdW] <= ResultW;
                end
            end
        end else begin : gen_rf_keep
            always_ff @(posedge clk) begin
                if (reset && rf_we) regs[RdW] <= ResultW;
            end
        end
    endgenerate

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_ctrl   = ALU_ADD;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        illegal    = 1'b0;
        is_auipc   = 1'b0;
        imm_d      = 32'd0;
        case (InstrD[6:0])
            OP_R: begin
                reg_write = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                alu_ctrl  = alu_decode(funct3, alt, 1'b1);
            end
            OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                rs1_used  = 1'b1;
                alu_ctrl  = alu_decode(funct3, alt, 1'b0);
                imm_d     = imm_i;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                alu_src    = 1'b1;
                rs1_used   = 1'b1;
                imm_d      = imm_i;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
                imm_d     = imm_s;
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm_d    = imm_b;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                alu_src    = 1'b1;
                jump       = 1'b1;
                imm_d      = imm_j;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                result_src = 2'b10;
                alu_src    = 1'b1;
                jump       = 1'b1;
                rs1_used   = 1'b1;
                imm_d      = imm_i;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_d     = imm_u;
            end
            OP_AUIPC: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                is_auipc  = 1'b1;
                imm_d     = imm_u;
            end
            default: illegal = 1'b1;
        endcase
    end

    // LUI falls through to zero because it never uses rs1
    assign rd1_d = is_auipc ? PCD : (rs1_used ? rf_rs1 : 32'd0);
    assign rd2_d = rs2_used ? rf_rs2 : 32'd0;

    assign hazard = ValidE && (CtrlE[8:7] == 2'b01) && (RdE != 5'd0) &&
                    (((RdE == rs1) && rs1_used) || ((RdE == rs2) && rs2_used));
    assign StallD = hazard && !FlushE;

    // Flush and stall both load a bubble; IF/ID re-presents the stalled instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ValidE   <= 1'b0;
            CtrlE    <= '0;
            Funct3E  <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            InstrE   <= '0;
            IllegalE <= 1'b0;
        end else if (FlushE || StallD) begin
            ValidE   <= 1'b0;
            CtrlE    <= '0;
            Funct3E  <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            ImmExtE  <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
            InstrE   <= NOP_INSTR;
            IllegalE <= 1'b0;
        end else begin
            ValidE   <= 1'b1;
            CtrlE    <= {reg_write, mem_write, result_src, alu_src, branch, jump, alu_ctrl};
            Funct3E  <= funct3;
            RD1E     <= rd1_d;
            RD2E     <= rd2_d;
            ImmExtE  <= imm_d;
            Rs1E     <= rs1_used ? rs1 : 5'd0;
            Rs2E     <= rs2_used ? rs2 : 5'd0;
            RdE      <= reg_write ? rd : 5'd0;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
            InstrE   <= InstrD;
            IllegalE <= illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized instruction streams,
// all checked against an opcode-set reference model of the ID/EX contents.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic        StallD, ValidE, IllegalE;
    logic [10:0] CtrlE;
    logic [2:0]  Funct3E;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, InstrE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    decode_stage dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .StallD(StallD), .ValidE(ValidE), .CtrlE(CtrlE), .Funct3E(Funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E), .InstrE(InstrE), .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] rfModel [32];
    logic        eValid, eIll;
    logic [10:0] eCtrl;
    logic [2:0]  eF3;
    logic [31:0] eRd1, eRd2, eImm, ePc, ePc4, eInstr;
    logic [4:0]  eRs1, eRs2, eRd;
    logic        mStall, lastStall;
    logic [3:0]  aluTab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] readModel(input logic [4:0] idx, input logic rw,
                                              input logic [4:0] rdw, input logic [31:0] resw);
        if (idx == 5'd0) return 32'd0;
        if (rw && rdw == idx) return resw;
        return rfModel[idx];
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] r2, r1,
                                         input logic [2:0] f3, input logic [4:0] rdx);
        return {f7, r2, r1, f3, rdx, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rdx,
                                         input logic [6:0] op);
        return {imm, r1, f3, rdx, op};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] r2, r1,
                                         input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 32; i++) rfModel[i] = 32'd0;
        {eValid, eIll, eCtrl, eF3, eRd1, eRd2, eImm, ePc, ePc4, eInstr, eRs1, eRs2, eRd} = '0;
        mStall = 1'b0;
    endtask

    task automatic compareAll();
        checkOutput("ValidE", 32'(ValidE), 32'(eValid));
        checkOutput("CtrlE", 32'(CtrlE), 32'(eCtrl));
        checkOutput("Funct3E", 32'(Funct3E), 32'(eF3));
        checkOutput("RD1E", RD1E, eRd1);
        checkOutput("RD2E", RD2E, eRd2);
        checkOutput("ImmExtE", ImmExtE, eImm);
        checkOutput("Rs1E", 32'(Rs1E), 32'(eRs1));
        checkOutput("Rs2E", 32'(Rs2E), 32'(eRs2));
        checkOutput("RdE", 32'(RdE), 32'(eRd));
        checkOutput("PCE", PCE, ePc);
        checkOutput("PCPlus4E", PCPlus4E, ePc4);
        checkOutput("InstrE", InstrE, eInstr);
        checkOutput("IllegalE", 32'(IllegalE), 32'(eIll));
    endtask

    // Called at a falling edge; returns at the next falling edge with E outputs checked
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic flush, input logic rw, input logic [4:0] rdw,
                                 input logic [31:0] resw);
        logic [6:0] op;
        logic isR, isI, isL, isS, isB, isJal, isJalr, isLui, isAuipc, legal;
        logic useRs1, useRs2, writesRd;
        logic [3:0] alu;
        int si;
        logic [31:0] imm;
        op = instr[6:0];
        isR = (op == 7'h33); isI = (op == 7'h13); isL = (op == 7'h03);
        isS = (op == 7'h23); isB = (op == 7'h63); isJal = (op == 7'h6F);
        isJalr = (op == 7'h67); isLui = (op == 7'h37); isAuipc = (op == 7'h17);
        legal = isR | isI | isL | isS | isB | isJal | isJalr | isLui | isAuipc;
        useRs1 = isR | isI | isL | isS | isB | isJalr;
        useRs2 = isR | isS | isB;
        writesRd = legal & !(isS | isB);
        alu = 4'd0;
        if (isR | isI) begin
            alu = aluTab[instr[14:12]];
            if (instr[30] && instr[14:12] == 3'd5) alu = 4'd7;
            if (instr[30] && instr[14:12] == 3'd0 && isR) alu = 4'd1;
        end
        si = int'(instr);
        imm = 32'd0;
        if (isI | isL | isJalr) imm = 32'(si >>> 20);
        if (isS) imm = 32'(((si >>> 25) <<< 5) | int'(instr[11:7]));
        if (isB) imm = 32'(((si >>> 31) <<< 12) | (int'(instr[7]) << 11) |
                           (int'(instr[30:25]) << 5) | (int'(instr[11:8]) << 1));
        if (isLui | isAuipc) imm = instr & 32'hFFFF_F000;
        if (isJal) imm = 32'(((si >>> 31) <<< 20) | (int'(instr[19:12]) << 12) |
                             (int'(instr[20]) << 11) | (int'(instr[30:21]) << 1));

        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        FlushE = flush; RegWriteW = rw; RdW = rdw; ResultW = resw;
        mStall = eValid && eCtrl[8:7] == 2'b01 && eRd != 5'd0 && !flush &&
                 ((useRs1 && eRd == instr[19:15]) || (useRs2 && eRd == instr[24:20]));
        #1;
        lastStall = StallD;
        checkOutput("StallD", 32'(StallD), 32'(mStall));
        @(posedge clk);
        if (flush || mStall) begin
            {eValid, eIll, eCtrl, eF3, eRd1, eRd2, eImm, ePc, ePc4, eRs1, eRs2, eRd} = '0;
            eInstr = 32'h0000_0013;
        end else begin
            eValid = 1'b1;
            eIll   = !legal;
            eCtrl  = legal ? {writesRd, isS, isL ? 2'b01 : ((isJal | isJalr) ? 2'b10 : 2'b00),
                              !(isR | isB), isB, isJal | isJalr, alu} : 11'd0;
            eF3    = instr[14:12];
            eRd1   = isAuipc ? pc : (useRs1 ? readModel(instr[19:15], rw, rdw, resw) : 32'd0);
            eRd2   = useRs2 ? readModel(instr[24:20], rw, rdw, resw) : 32'd0;
            eImm   = imm;
            eRs1   = useRs1 ? instr[19:15] : 5'd0;
            eRs2   = useRs2 ? instr[24:20] : 5'd0;
            eRd    = writesRd ? instr[11:7] : 5'd0;
            ePc    = pc;
            ePc4   = pc + 32'd4;
            eInstr = instr;
        end
        if (rw && rdw != 5'd0) rfModel[rdw] = resw;
        #1;
        compareAll();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b0;
        #1;
        clearModel();
        compareAll();
        @(negedge clk);
        reset = 1'b1;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        logic [31:0] instr, pc;
        logic [6:0]  opTab [10];
        opTab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0B};
        InstrD = NOP; PCD = '0; PCPlus4D = 32'd4; FlushE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
        lastStall = 1'b0;
        doReset();

        applyStimulus(NOP, 32'h0, 0, 0, 0, 0);
        checkOutput("t1_valid", 32'(ValidE), 32'd1);
        checkOutput("t1_ctrl", 32'(CtrlE), 32'h440);

        applyStimulus(encR(7'd0, 5'd0, 5'd5, 3'd0, 5'd6), 32'h4, 0, 1, 5'd5, 32'hDEAD_BEEF);
        checkOutput("t2_bypass", RD1E, 32'hDEAD_BEEF);

        applyStimulus(encI(12'd0, 5'd1, 3'd2, 5'd7, 7'h03), 32'h8, 0, 0, 0, 0);
        applyStimulus(encR(7'd0, 5'd2, 5'd7, 3'd0, 5'd8), 32'hC, 0, 0, 0, 0);
        checkOutput("t3_stall", 32'(lastStall), 32'd1);
        checkOutput("t3_bubble", 32'(ValidE), 32'd0);
        applyStimulus(encR(7'd0, 5'd2, 5'd7, 3'd0, 5'd8), 32'hC, 0, 0, 0, 0);
        checkOutput("t3_nostall", 32'(lastStall), 32'd0);
        checkOutput("t3_issue_rd", 32'(RdE), 32'd8);

        applyStimulus(encI(12'd0, 5'd1, 3'd2, 5'd7, 7'h03), 32'h10, 0, 0, 0, 0);
        applyStimulus(encR(7'd0, 5'd2, 5'd7, 3'd0, 5'd8), 32'h14, 1, 0, 0, 0);
        checkOutput("t4_stall", 32'(lastStall), 32'd0);
        checkOutput("t4_bubble", 32'(ValidE), 32'd0);

        applyStimulus(encB(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h100, 0, 0, 0, 0);
        checkOutput("t5_imm", ImmExtE, 32'hFFFF_FFF8);
        checkOutput("t5_branch", 32'(CtrlE[5]), 32'd1);
        checkOutput("t5_f3", 32'(Funct3E), 32'd0);
        checkOutput("t5_rd", 32'(RdE), 32'd0);

        applyStimulus(32'h0000_007F, 32'h104, 0, 0, 0, 0);
        checkOutput("t6_illegal", 32'(IllegalE), 32'd1);
        checkOutput("t6_ctrl", 32'(CtrlE), 32'd0);
        applyStimulus(encR(7'd0, 5'd0, 5'd0, 3'd0, 5'd9), 32'h108, 0, 1, 5'd0, 32'hFFFF_FFFF);
        checkOutput("t6_x0_bypass", RD1E, 32'd0);
        applyStimulus(encR(7'd0, 5'd0, 5'd0, 3'd0, 5'd9), 32'h10C, 0, 0, 0, 0);
        checkOutput("t6_x0_read", RD1E, 32'd0);

        pc = 32'h200;
        instr = NOP;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) doReset();
            if (!mStall) begin
                instr = $urandom;
                instr[6:0] = opTab[$urandom_range(0, 9)];
                instr[11:7] = 5'($urandom_range(0, 7));
                instr[19:15] = 5'($urandom_range(0, 7));
                instr[24:20] = 5'($urandom_range(0, 7));
                pc = pc + 32'd4;
            end
            applyStimulus(instr, pc, ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
